// File: rtl/instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// instr_fetch_stage
//
// Purpose:
//   Instruction fetch stage. Owns the program counter, fetches 32-bit words
//   from instruction memory over a req/ack handshake and holds the result in
//   a single-entry IF/ID register. id_instruction feeds the instruction field
//   splitter directly. Handles downstream stall (id_ready) and branch/jump
//   redirects, flushing both an in-flight request and a held instruction.
//
// Handshakes:
//   imem_req/imem_ack : imem_req rises with a stable imem_addr and both stay
//     put until a cycle in which imem_ack=1; that cycle carries imem_rdata.
//     imem_ack is ignored whenever imem_req=0.
//   id_valid/id_ready : the held word moves downstream on a rising edge where
//     id_valid=1, id_ready=1 and redirect_valid=0. A redirect in that same
//     cycle wins and the held word is dropped instead.
//
// Parameters:
//   RESET_PC       PC loaded on reset (word aligned; low bits are forced to 0).
//
// Ports:
//   clk            clock, rising edge
//   rst_n          synchronous active-low reset
//   imem_req       fetch request (FETCH and DRAIN only)
//   imem_addr      word-aligned fetch address
//   imem_ack       memory returns imem_rdata this cycle
//   imem_rdata     fetched instruction word
//   redirect_valid taken branch/jump, one-cycle pulse
//   redirect_pc    redirect target; bits [1:0] ignored
//   id_ready       downstream accepts the held instruction
//   id_valid       IF/ID register holds a valid instruction
//   id_instruction held instruction word
//   id_pc          address of the held instruction
//   id_pc_plus4    id_pc + 4 (mod 2^32)
//
// Optional build macro INSTR_FETCH_PERF_EN adds:
//   perf_fetched   saturating count of IF/ID transfers
//   perf_flushed   saturating count of redirects that threw work away
//                  (held word dropped, same-cycle ack discarded, or DRAIN
//                  entered)
//
// Debug visibility: the FSM state is the register state_q (type state_t).
// -----------------------------------------------------------------------------
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc,
`ifdef INSTR_FETCH_PERF_EN
    output logic [31:0] id_pc_plus4,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
`else
    output logic [31:0] id_pc_plus4
`endif
);

    // IDLE  : one cycle after reset, no request.
    // FETCH : request outstanding at pc_q.
    // DRAIN : request outstanding at an address made stale by a redirect;
    //         its data will be thrown away.
    // HOLD  : IF/ID register full, waiting for id_ready.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instruction_q, id_instruction_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;

    logic [31:0] redirect_target;
    logic [31:0] pc_plus4;
    logic        transfer;
    logic        flush_event;

    // The two low target bits carry no information for word fetches.
    logic        unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign redirect_target = {redirect_pc[31:2], 2'b00};
    // Natural 32-bit wrap takes 32'hFFFF_FFFC to 0.
    assign pc_plus4        = pc_q + 32'd4;

    // A handshake in HOLD only counts when no redirect overrides it.
    assign transfer    = (state_q == HOLD) && id_valid_q && id_ready && !redirect_valid;
    // A redirect discards work only when something useful was in flight or
    // held: a held word (HOLD) or a live request (FETCH, whether or not it is
    // acked this cycle). Redirects in DRAIN or IDLE discard nothing new.
    assign flush_event = redirect_valid && ((state_q == HOLD) || (state_q == FETCH));

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        drain_addr_d     = drain_addr_q;
        id_valid_d       = id_valid_q;
        id_instruction_d = id_instruction_q;
        id_pc_d          = id_pc_q;
        id_pc_plus4_d    = id_pc_plus4_q;

        unique case (state_q)
            IDLE: begin
                // Redirect here only steers where the first fetch goes.
                state_d = FETCH;
                if (redirect_valid) begin
                    pc_d = redirect_target;
                end
            end

            FETCH: begin
                if (redirect_valid) begin
                    pc_d       = redirect_target;
                    id_valid_d = 1'b0;
                    if (imem_ack) begin
                        // Returning word belongs to the old path: drop it and
                        // start the new path immediately.
                        state_d = FETCH;
                    end else begin
                        // Request cannot be withdrawn; remember its address
                        // so imem_addr stays stable until the ack.
                        state_d      = DRAIN;
                        drain_addr_d = pc_q;
                    end
                end else if (imem_ack) begin
                    id_instruction_d = imem_rdata;
                    id_pc_d          = pc_q;
                    id_pc_plus4_d    = pc_plus4;
                    id_valid_d       = 1'b1;
                    pc_d             = pc_plus4;
                    state_d          = HOLD;
                end
            end

            DRAIN: begin
                if (redirect_valid) begin
                    // Newest target wins; the stale request is still pending.
                    pc_d       = redirect_target;
                    id_valid_d = 1'b0;
                end
                if (imem_ack) begin
                    state_d = FETCH;
                end
            end

            HOLD: begin
                if (redirect_valid) begin
                    pc_d       = redirect_target;
                    id_valid_d = 1'b0;
                    state_d    = FETCH;
                end else if (id_ready) begin
                    id_valid_d = 1'b0;
                    state_d    = FETCH;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            pc_q             <= RESET_PC_ALIGNED;
            drain_addr_q     <= 32'd0;
            id_valid_q       <= 1'b0;
            id_instruction_q <= 32'd0;
            id_pc_q          <= 32'd0;
            id_pc_plus4_q    <= 32'd0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            drain_addr_q     <= drain_addr_d;
            id_valid_q       <= id_valid_d;
            id_instruction_q <= id_instruction_d;
            id_pc_q          <= id_pc_d;
            id_pc_plus4_q    <= id_pc_plus4_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign imem_req       = (state_q == FETCH) || (state_q == DRAIN);
    assign imem_addr      = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign id_valid       = id_valid_q;
    assign id_instruction = id_instruction_q;
    assign id_pc          = id_pc_q;
    assign id_pc_plus4    = id_pc_plus4_q;

`ifdef INSTR_FETCH_PERF_EN
    // -------------------------------------------------------------------------
    // Performance counters (saturating)
    // -------------------------------------------------------------------------
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_flushed_q, perf_flushed_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_flushed_d = perf_flushed_q;
        if (transfer && (perf_fetched_q != 32'hFFFF_FFFF)) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
        if (flush_event && (perf_flushed_q != 32'hFFFF_FFFF)) begin
            perf_flushed_d = perf_flushed_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched_q <= 32'd0;
            perf_flushed_q <= 32'd0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushed_q <= perf_flushed_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`else
    // Event terms only feed the optional counters.
    logic unused_perf_events;
    assign unused_perf_events = transfer ^ flush_event;
`endif

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- Upstream neighbour of the instruction field splitter: owns the PC, fetches 32-bit words from instruction memory over a req/ack handshake, and holds them in a single-entry IF/ID register.
- id_instruction drives the splitter's instruction_in directly.
- Handles downstream stall (id_ready) and branch/jump redirect with flush of in-flight and held instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; low two bits must be 0.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  reset; one clock, reset is synchronous and active-low.
- imem_req  out  1  fetch request; held high, with imem_addr stable, until imem_ack.
- imem_addr  out  32  word-aligned fetch address.
- imem_ack  in  1  memory returns imem_rdata this cycle; only meaningful while imem_req=1.
- imem_rdata  in  32  fetched instruction word.
- redirect_valid  in  1  branch/jump taken; one-cycle pulse.
- redirect_pc  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- id_ready  in  1  downstream accepts the held instruction this cycle.
- id_valid  out  1  IF/ID register holds a valid instruction.
- id_instruction  out  32  held instruction word, to the splitter.
- id_pc  out  32  address of the held instruction.
- id_pc_plus4  out  32  id_pc+4, mod 2^32.

Behaviour:
- States: IDLE, FETCH, DRAIN, HOLD.
- Reset (rst_n=0 at edge):
  - state=IDLE, pc=RESET_PC.
  - id_valid=0, id_instruction=0, id_pc=0, id_pc_plus4=0.
  - imem_req=0.
- Outputs:
  - imem_req=1 in FETCH and DRAIN only.
  - imem_addr=pc in FETCH; the latched outstanding address in DRAIN; pc otherwise.
- IDLE -> FETCH unconditionally. First request is asserted the second cycle after rst_n rises.
- FETCH, on ack:
  - id_instruction=imem_rdata, id_pc=pc, id_pc_plus4=pc+4, id_valid=1.
  - pc=pc+4, wrapping 32'hFFFF_FFFC -> 0.
  - state -> HOLD.
- FETCH, no ack: stay; request and address held stable.
- HOLD:
  - No request is issued.
  - If id_ready: id_valid=0, -> FETCH.
  - Otherwise outputs are held unchanged.
  - Latency: ack to id_valid is 1 cycle. Handshake to next imem_req is 1 cycle. Peak throughput is one instruction per 3 cycles with a 1-cycle-ack memory.
- DRAIN:
  - Request outstanding after a redirect; keep imem_req=1 with the old address.
  - On ack: discard rdata, -> FETCH.
- Redirect has priority over all other events and is valid in every state except IDLE, where it only loads pc:
  - pc = {redirect_pc[31:2],2'b00}; id_valid=0 next cycle.
  - FETCH with ack the same cycle: data discarded, -> FETCH at the new pc.
  - FETCH without ack: -> DRAIN.
  - DRAIN with ack: -> FETCH. DRAIN without ack: stay in DRAIN; pc takes the newest target.
  - HOLD: held instruction is dropped even if id_ready=1 that cycle (no transfer counted), -> FETCH.
- id_valid&&id_ready is a transfer only when redirect_valid=0.
- imem_ack outside FETCH/DRAIN is ignored.
- Reset mid-fetch: the outstanding request is abandoned. Memory must tolerate a request dropped without ack; any later ack is ignored in IDLE.

Optional Feature:
- Macro: INSTR_FETCH_PERF_EN.
- Defined: adds outputs perf_fetched (32) and perf_flushed (32), both reset to 0, saturating at 32'hFFFF_FFFF.
  - perf_fetched increments per transfer.
  - perf_flushed increments per redirect that discards a held instruction, a same-cycle ack, or enters DRAIN.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset release, RESET_PC=0x100, ack 1 cycle after each req, id_ready=1:
  - imem_addr sequence 0x100, 0x104, 0x108.
  - id_pc/id_instruction match each ack; id_pc_plus4=0x104 for the first.
- id_ready=0 for 5 cycles after the first ack:
  - id_valid stays 1 with stable outputs; imem_req stays 0.
  - Next request 0x104 issues 1 cycle after id_ready rises.
- Redirect to 0x2003 while FETCH waits, ack 3 cycles later:
  - DRAIN keeps imem_addr at the old address; rdata discarded, id_valid stays 0.
  - Next request is imem_addr=0x2000.
- Redirect to 0x400 in HOLD with id_ready=1 the same cycle: id_valid=0 next cycle, no transfer, next imem_addr=0x400.
- Redirect to 0xFFFF_FFFC then ack: id_pc_plus4=0x0, next imem_addr=0x0.
- Assert rst_n=0 in DRAIN, ack arrives during IDLE: ack ignored, id_valid=0, first request at RESET_PC; with INSTR_FETCH_PERF_EN, counters read 0.
